// File: rtl/des_pkg.sv
// des_pkg: types and defaults shared by the DES block scheduler.
`default_nettype none

package des_pkg;

  typedef logic [7:0][7:0] block_t;
  typedef logic [7:0][7:0] key_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FIRE = 3'd2,
    S_WAIT = 3'd3,
    S_ACK  = 3'd4,
    S_OUT  = 3'd5,
    S_FIN  = 3'd6,
    S_ERR  = 3'd7
  } sched_state_e;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

`default_nettype wire

// File: rtl/des_block_sched.sv
// ----------------------------------------------------------------------------
// des_block_sched: runs a single-block DES decrypt core over an N-block job.
// Optional CBC chaining under DES_SCHED_CBC_EN.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module des_block_sched
  import des_pkg::*;
#(
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 64,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_blocks,
  input  logic [KEY_W-1:0]   key_in,
  input  logic [BLOCK_W-1:0] iv_in,
  input  logic               in_valid,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [BLOCK_W-1:0] out_data,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] core_message,
  output logic [KEY_W-1:0]   core_key,
  output logic               core_enable,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result,
  output logic               core_ack,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [CNT_W-1:0]   blocks_done
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT - 1);

  sched_state_e       r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [BLOCK_W-1:0] r_out_data;
  logic [BLOCK_W-1:0] r_core_message;
  logic [KEY_W-1:0]   r_core_key;
  logic               r_core_enable;
  logic               r_core_ack;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [CNT_W-1:0]   r_blocks_done;
  logic [CNT_W-1:0]   r_remaining;
  logic [TMR_W-1:0]   r_timer;
  logic [BLOCK_W-1:0] w_plain;

`ifdef DES_SCHED_CBC_EN
  logic [BLOCK_W-1:0] r_chain;
  assign w_plain = core_result ^ r_chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chain <= '0;
    end else if ((r_state == S_IDLE || r_state == S_ERR) && start) begin
      r_chain <= iv_in;
    end else if (r_state == S_OUT && out_ready) begin
      // the ciphertext just decrypted chains into the next block
      r_chain <= r_core_message;
    end
  end
`else
  logic w_unused_iv;
  assign w_unused_iv = ^iv_in;
  assign w_plain     = core_result;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_in_ready     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_core_message <= '0;
      r_core_key     <= '0;
      r_core_enable  <= 1'b0;
      r_core_ack     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_blocks_done  <= '0;
      r_remaining    <= '0;
      r_timer        <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR: begin
          if (start) begin
            r_error       <= 1'b0;
            r_blocks_done <= '0;
            r_busy        <= 1'b1;
            if (num_blocks != '0) begin
              r_core_key  <= key_in;
              r_remaining <= num_blocks;
              r_in_ready  <= 1'b1;
              r_state     <= S_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_core_message <= in_data;
            r_in_ready     <= 1'b0;
            r_core_enable  <= 1'b1;
            r_state        <= S_FIRE;
          end
        end
        S_FIRE: begin
          r_core_enable <= 1'b0;
          r_timer       <= '0;
          r_state       <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            r_out_data <= w_plain;
            r_core_ack <= 1'b1;
            r_state    <= S_ACK;
          end else if (r_timer == c_TMR_LAST) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_ERR;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_ACK: begin
          r_core_ack  <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid   <= 1'b0;
            r_blocks_done <= r_blocks_done + 1'b1;
            r_remaining   <= r_remaining - 1'b1;
            if (r_remaining == CNT_W'(1)) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= S_LOAD;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign core_message = r_core_message;
  assign core_key     = r_core_key;
  assign core_enable  = r_core_enable;
  assign core_ack     = r_core_ack;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign blocks_done  = r_blocks_done;

endmodule

`default_nettype wire

// File: tb/tb_des_block_sched.sv
// tb_des_block_sched: randomized jobs against a job-level reference model and
// a behavioural DES core stand-in (result = message ^ key, fixed latency).
`default_nettype none

module tb_des_block_sched;
  import des_pkg::*;

  localparam int CORE_LAT = 16;
  localparam int TO       = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_blocks = '0;
  logic [63:0] key_in = '0;
  logic [63:0] iv_in = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready = 1'b0;
  logic [63:0] core_message;
  logic [63:0] core_key;
  logic        core_enable;
  logic        core_done = 1'b0;
  logic [63:0] core_result = '0;
  logic        core_ack;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] blocks_done;

  des_block_sched #(.BLOCK_W(64), .KEY_W(64), .CNT_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
    .key_in(key_in), .iv_in(iv_in), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .core_message(core_message), .core_key(core_key),
    .core_enable(core_enable), .core_done(core_done), .core_result(core_result),
    .core_ack(core_ack), .busy(busy), .done(done), .error(error),
    .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core stand-in, driven on the falling edge so the DUT sees stable values.
  logic core_mute = 1'b0;
  int   n_en = 0, n_ack = 0, lat_cnt = 0;
  logic pending = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      core_done = 1'b0;
      pending   = 1'b0;
      lat_cnt   = 0;
    end else begin
      if (core_ack) begin
        n_ack++;
        core_done = 1'b0;
      end
      if (core_enable) begin
        n_en++;
        pending     = 1'b1;
        lat_cnt     = 0;
        core_result = core_message ^ core_key;
      end else if (pending) begin
        lat_cnt++;
        if (core_mute) pending = 1'b0;
        else if (lat_cnt == CORE_LAT) begin
          core_done = 1'b1;
          pending   = 1'b0;
        end
      end
    end
  end

  logic [63:0] blk_q[$];
  logic [63:0] exp_q[$];

  // Job-level reference: plaintext = D(c) ^ previous ciphertext (IV first) in CBC.
  task automatic build_expect(input logic [63:0] key, input logic [63:0] iv);
    logic [63:0] prev;
    prev = iv;
    exp_q.delete();
    foreach (blk_q[i]) begin
`ifdef DES_SCHED_CBC_EN
      exp_q.push_back((blk_q[i] ^ key) ^ prev);
`else
      exp_q.push_back(blk_q[i] ^ key);
`endif
      prev = blk_q[i];
    end
  endtask

  task automatic start_job(input int n, input logic [63:0] key, input logic [63:0] iv);
    start = 1'b1; num_blocks = 16'(n); key_in = key; iv_in = iv;
    @(negedge clk);
    start = 1'b0; key_in = {$urandom, $urandom}; iv_in = {$urandom, $urandom};
  endtask

  task automatic feed(input int maxgap);
    foreach (blk_q[i]) begin
      int guard = 0;
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      in_valid = 1'b1; in_data = blk_q[i];
      while (!in_ready && guard < 400) begin @(negedge clk); guard++; end
      if (!in_ready) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      in_valid = 1'b0; in_data = {$urandom, $urandom};
    end
  endtask

  task automatic sink(input int n, input int stall);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      logic [63:0] hold, exp;
      while (!out_valid && guard < 400) begin @(negedge clk); guard++; end
      if (!out_valid) begin
        chk("out_valid_timeout", 0, 1);
        return;
      end
      exp = exp_q.pop_front();
      chk("out_data", out_data, exp);
      hold = out_data;
      repeat (stall) begin
        @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("blocks_done", blocks_done, 64'(i + 1));
      if (i == n - 1) begin
        chk("done_after_hs", done, 1);
        chk("busy_in_fin", busy, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
      end
    end
  endtask

  task automatic run_job(input int n, input logic [63:0] key, input logic [63:0] iv,
                         input int stall, input int maxgap, input bit poke);
    int en0, ack0;
    build_expect(key, iv);
    en0 = n_en; ack0 = n_ack;
    start_job(n, key, iv);
    fork
      feed(maxgap);
      sink(n, stall);
      if (poke) begin
        repeat (8) @(negedge clk);
        start = 1'b1; num_blocks = 16'd7; key_in = {$urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
      end
    join
    chk("enable_count", 64'(n_en - en0), 64'(n));
    chk("ack_count", 64'(n_ack - ack0), 64'(n));
  endtask

  initial begin
    logic [63:0] k;
    int en0, ack0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_core_en", core_enable, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_blocks_done", blocks_done, 0);
    reset = 1'b1;
    @(negedge clk);

    // single block, known strings
    blk_q = {64'("waterbot")};
    run_job(1, 64'("hellodar"), 64'h0, 0, 0, 0);

    // four random blocks, input gaps and 5-cycle output stalls
    blk_q.delete();
    repeat (4) blk_q.push_back({$urandom, $urandom});
    run_job(4, {$urandom, $urandom}, 64'h0, 5, 4, 0);

    // three blocks with a fixed IV (chaining applies only in CBC builds)
    blk_q.delete();
    repeat (3) blk_q.push_back({$urandom, $urandom});
    run_job(3, {$urandom, $urandom}, 64'h0123456789ABCDEF, 1, 2, 0);

    // start while busy must not disturb the running job
    blk_q.delete();
    repeat (2) blk_q.push_back({$urandom, $urandom});
    run_job(2, {$urandom, $urandom}, {$urandom, $urandom}, 2, 1, 1);

    for (int j = 0; j < 3; j++) begin
      int n;
      n = $urandom_range(1, 5);
      blk_q.delete();
      repeat (n) blk_q.push_back({$urandom, $urandom});
      run_job(n, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    // zero-block job
    en0 = n_en;
    start = 1'b1; num_blocks = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    @(negedge clk);
    chk("zero_done_pulse", done, 0);
    chk("zero_no_enable", 64'(n_en - en0), 0);

    // core timeout: error after TO wait cycles following the FIRE cycle
    core_mute = 1'b1;
    ack0 = n_ack;
    blk_q = {64'h1122334455667788};
    start_job(1, 64'hA5A5A5A5A5A5A5A5, 64'h0);
    feed(0);
    chk("to_fire", core_enable, 1);
    repeat (TO) @(negedge clk);
    chk("to_error_early", error, 0);
    @(negedge clk);
    chk("to_error", error, 1);
    chk("to_busy", busy, 0);
    chk("to_state", 64'(dut.r_state), 64'(S_ERR));
    chk("to_no_out", out_valid, 0);
    chk("to_no_ack", 64'(n_ack - ack0), 0);
    core_mute = 1'b0;
    blk_q.delete();
    repeat (2) blk_q.push_back({$urandom, $urandom});
    build_expect(64'h0F0F0F0F0F0F0F0F, 64'h55);
    start_job(2, 64'h0F0F0F0F0F0F0F0F, 64'h55);
    chk("err_cleared", error, 0);
    fork
      feed(1);
      sink(2, 1);
    join

    // asynchronous reset in the middle of WAIT
    blk_q = {64'hDEADBEEFCAFEF00D};
    start_job(1, 64'h8877665544332211, 64'h0);
    feed(0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_core_key", core_key, 0);
    chk("mid_rst_core_msg", core_message, 0);
    chk("mid_rst_enable", core_enable, 0);
    chk("mid_rst_ack", core_ack, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    blk_q = {64'h0102030405060708};
    run_job(1, 64'h1111111111111111, 64'h2222, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/des_block_sched.md
Name: des_block_sched

Overview:
- Sequences the single-block DES `decrypt` core over a multi-block image stream.
- Accepts N 64-bit ciphertext blocks on a valid/ready input and loads each into the core with the job key.
- Drives the core's enable/done/ack handshake and emits plaintext blocks on a valid/ready output.
- Sits between the image buffer DMA and the `decrypt` instance; one job = N blocks under one key.

Parameters:
- BLOCK_W, 64, block width in bits (DES block).
- KEY_W, 64, key width in bits.
- CNT_W, 16, width of the block-count and progress counters.
- TIMEOUT, 1024, maximum cycles in WAIT for core_done before the error state; must be ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; sampled only in IDLE or ERR.
- num_blocks  in  CNT_W  blocks in the job; sampled with start.
- key_in  in  KEY_W  job key; sampled with start.
- iv_in  in  BLOCK_W  chaining IV; sampled with start; ignored without CBC_EN.
- in_valid  in  1  ciphertext block valid.
- in_data  in  BLOCK_W  ciphertext block.
- in_ready  out  1  scheduler accepts a block.
- out_valid  out  1  plaintext block valid.
- out_data  out  BLOCK_W  plaintext block.
- out_ready  in  1  sink accepts a block.
- core_message  out  BLOCK_W  registered block to the core.
- core_key  out  KEY_W  registered key to the core.
- core_enable  out  1  one-cycle start pulse to the core.
- core_done  in  1  core result valid; held until core_ack.
- core_result  in  BLOCK_W  core output.
- core_ack  out  1  one-cycle acknowledge to the core.
- busy  out  1  high in every state except IDLE and ERR.
- done  out  1  one-cycle job-complete pulse.
- error  out  1  sticky core timeout flag.
- blocks_done  out  CNT_W  plaintext blocks accepted by the sink in the current job.

Behaviour:
- Reset: every output and register is 0; FSM enters IDLE. Reset mid-job abandons the job silently.
- FSM states: IDLE, LOAD, FIRE, WAIT, ACK, OUT, FIN, ERR.
- IDLE/ERR, start=1, num_blocks≠0: latch key_in to core_key and iv_in to chain; remaining=num_blocks; blocks_done=0; error=0; go to LOAD.
- IDLE/ERR, start=1, num_blocks=0: go to FIN (done pulse); error is cleared.
- start in any other state is ignored.
- LOAD: in_ready=1. When in_valid=1, register in_data to core_message and go to FIRE. in_ready is 0 in every other state.
- FIRE: core_enable=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT: when core_done=1, register core_result (see Optional Feature) to out_data and go to ACK.
- WAIT timeout: when the timer reaches TIMEOUT-1 with no done, set error=1 and go to ERR. Nothing is output and core_ack is not driven.
- ACK: core_ack=1 for exactly one cycle; go to OUT.
- OUT: out_valid=1; out_data is stable until out_ready=1.
- OUT handshake: on out_ready=1, blocks_done+1 and remaining-1. Go to FIN if remaining was 1, otherwise LOAD.
- FIN: done=1 for one cycle; go to IDLE. blocks_done holds until the next start.
- Minimum per-block latency is 4 cycles plus core latency (accept→FIRE→WAIT(≥1)→ACK→OUT), with zero backpressure.
- num_blocks=2^CNT_W-1 must complete without counter wrap.

Optional Feature:
- Macro: DES_SCHED_CBC_EN.
- Defined (CBC decrypt): out_data = core_result XOR chain. On the OUT handshake, chain ← the core_message of that block. The first block chains with iv_in.
- Undefined (ECB): out_data = core_result; the chain register and iv_in are removed.

Decomposition:
- Package des_pkg holds:
  - block_t and key_t (logic [7:0][7:0]);
  - the sched_state_e enum;
  - the default TIMEOUT constant.
- No sub-module; the timeout counter stays inline. The `decrypt` core is instantiated at the level above, not inside.

Test Plan:
- Bench core model: 16-cycle latency; result = message XOR key; done holds until ack.
- ECB, 1 block: key "hellodar", block "waterbot". Expect:
  - out_data = "waterbot"^"hellodar";
  - exactly one core_enable and one core_ack;
  - done one cycle after the OUT handshake; blocks_done=1.
- ECB, 4 blocks with random in_valid gaps and out_ready held low for 5 cycles per block:
  - all 4 outputs are correct, in order, and stable while stalled;
  - busy falls at FIN.
- CBC_EN, 3 blocks, IV=64'h0123456789ABCDEF:
  - block0 = model^IV;
  - block1 = model^C0;
  - block2 = model^C1.
- Timeout: model never asserts done, TIMEOUT=32.
  - error=1 exactly 32 cycles after FIRE; FSM in ERR; busy=0.
  - A new start clears error and the job completes.
- Edge cases:
  - start with num_blocks=0 gives done the next cycle, with no core_enable.
  - reset asserted mid-WAIT drives all outputs to 0 immediately.
  - start asserted while busy is ignored.
